// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the round-robin 4-way mux arbiter: FSM state codes,
// channel/select codes and a one-hot helper.
package mux4_rr_arbiter_pkg;

  localparam int MUX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_UNUSED = 2'd3
  } state_t;

  // Channel indices double as mux select codes.
  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;
  localparam logic [1:0] S3 = 2'b11;

  function automatic logic [3:0] chan_onehot(input logic [1:0] ch);
    chan_onehot = 4'b0001 << ch;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux4_1.sv
// Plain 4-to-1 word multiplexer; select codes follow the channel constants.
module mux4_1 #(
  parameter int W = 4
) (
  input  logic [W-1:0] input0,
  input  logic [W-1:0] input1,
  input  logic [W-1:0] input2,
  input  logic [W-1:0] input3,
  input  logic [1:0]   sel,
  output logic [W-1:0] data_out
);
  import mux4_rr_arbiter_pkg::*;

  always_comb begin
    data_out = input0;
    case (sel)
      S0:      data_out = input0;
      S1:      data_out = input1;
      S2:      data_out = input2;
      S3:      data_out = input3;
      default: data_out = input0;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter in front of a shared mux4_1: grants one requester in IDLE,
// captures its word in LOAD and presents it with valid/ready in HOLD.
module mux4_rr_arbiter #(
  parameter int         DATA_W  = 4,
  parameter logic [1:0] RST_PTR = 2'b11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] input0,
  input  logic [DATA_W-1:0] input1,
  input  logic [DATA_W-1:0] input2,
  input  logic [DATA_W-1:0] input3,
  output logic [3:0]        ack,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_src,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);
  import mux4_rr_arbiter_pkg::*;

  state_t            state_reg, state_next;
  logic [1:0]        sel_reg;
  logic [1:0]        last_grant_reg;
  logic [3:0]        ack_reg;
  logic [3:0]        ack_set;
  logic [DATA_W-1:0] out_data_reg;
  logic [1:0]        out_src_reg;
  logic              out_valid_reg;
  logic [DATA_W-1:0] mux_data;
  logic [1:0]        winner;

  // First requester after the last grant; scanning +4 wraps back to last itself.
  function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] c;
    pick_winner = last + 2'd1;
    for (int k = 4; k >= 1; k--) begin
      c = last + 2'(k);
      if (r[c]) pick_winner = c;
    end
  endfunction

  assign winner = pick_winner(req, last_grant_reg);

  mux4_1 #(.W(DATA_W)) u_mux (
    .input0   (input0),
    .input1   (input1),
    .input2   (input2),
    .input3   (input3),
    .sel      (sel_reg),
    .data_out (mux_data)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_ack
    assign ack_set[gi] = (sel_reg == 2'(gi));
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = ST_IDLE;
    case (state_reg)
      ST_IDLE: state_next = (|req) ? ST_LOAD : ST_IDLE;
      ST_LOAD: state_next = ST_HOLD;
      ST_HOLD: state_next = out_ready ? ST_IDLE : ST_HOLD;
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath; the capture in LOAD ignores req so a dropped request still completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_reg        <= S0;
      last_grant_reg <= RST_PTR;
      ack_reg        <= '0;
      out_data_reg   <= '0;
      out_src_reg    <= '0;
      out_valid_reg  <= 1'b0;
    end else begin
      ack_reg <= '0;
      case (state_reg)
        ST_IDLE: if (|req) sel_reg <= winner;
        ST_LOAD: begin
          out_data_reg   <= mux_data;
          out_src_reg    <= sel_reg;
          out_valid_reg  <= 1'b1;
          ack_reg        <= ack_set;
          last_grant_reg <= sel_reg;
        end
        ST_HOLD: if (out_ready) out_valid_reg <= 1'b0;
        default: ;
      endcase
    end
  end

  assign ack       = ack_reg;
  assign out_data  = out_data_reg;
  assign out_src   = out_src_reg;
  assign out_valid = out_valid_reg;
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed plus randomized bench for mux4_rr_arbiter against a transaction-level
// round-robin model (last grant pointer + priority scan).
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] input0 = '0, input1 = '0, input2 = '0, input3 = '0;
  logic [3:0] ack;
  logic [3:0] out_data;
  logic [1:0] out_src;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy;

  int n_total = 0;
  int n_pass  = 0;
  int model_lg = 3;

  mux4_rr_arbiter #(.DATA_W(4), .RST_PTR(2'b11)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .input0    (input0),
    .input1    (input1),
    .input2    (input2),
    .input3    (input3),
    .ack       (ack),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int model_winner(input logic [3:0] r);
    model_winner = -1;
    for (int k = 4; k >= 1; k--)
      if (r[(model_lg + k) % 4]) model_winner = (model_lg + k) % 4;
  endfunction

  // One arbitration starting in IDLE: grant, capture, 'delay' stalled cycles, release.
  task automatic do_txn(input string name, input logic [3:0] r, input logic [15:0] dw, input int delay);
    int w;
    logic [3:0] exp_d;
    w = model_winner(r);
    exp_d = dw[w*4 +: 4];
    req = r;
    {input3, input2, input1, input0} = dw;
    out_ready = (delay == 0);
    cycle();
    chk({name, "_load_ack"}, ack, 0);
    chk({name, "_load_valid"}, out_valid, 0);
    chk({name, "_load_busy"}, busy, 1);
    cycle();
    chk({name, "_ack"}, ack, 32'(4'b0001 << w));
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_data"}, out_data, exp_d);
    chk({name, "_src"}, out_src, w);
    model_lg = w;
    $display("txn %s: req=%b grant=%0d data=%h stall=%0d", name, r, out_src, out_data, delay);
    for (int i = 0; i < delay; i++) begin
      cycle();
      chk({name, "_hold_valid"}, out_valid, 1);
      chk({name, "_hold_data"}, out_data, exp_d);
      chk({name, "_hold_src"}, out_src, w);
      chk({name, "_hold_ack"}, ack, 0);
    end
    out_ready = 1'b1;
    cycle();
    chk({name, "_rel_valid"}, out_valid, 0);
    chk({name, "_rel_busy"}, busy, 0);
    chk({name, "_rel_ack"}, ack, 0);
    out_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_ack"}, ack, 0);
    chk({name, "_data"}, out_data, 0);
    chk({name, "_src"}, out_src, 0);
    chk({name, "_valid"}, out_valid, 0);
    chk({name, "_busy"}, busy, 0);
  endtask

  initial begin
    // Reset with random inputs applied
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req = 4'($urandom); {input3, input2, input1, input0} = 16'($urandom);
      out_ready = 1'($urandom);
      cycle();
      chk_reset_outputs("reset");
    end
    reset = 1'b0;
    out_ready = 1'b0;
    model_lg = 3;
    do_txn("first", 4'b1111, 16'h4321, 0);

    // Idle: no request keeps the arbiter in IDLE
    req = 4'b0000;
    cycle();
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);

    // Single channel
    do_txn("single", 4'b0100, 16'h0A00, 0);

    // Round robin with all requests high
    model_lg = 3;
    reset = 1'b1; cycle(); reset = 1'b0;
    for (int i = 0; i < 5; i++) do_txn("rr", 4'b1111, 16'h4321, 0);

    // Backpressure on channel 3
    do_txn("bp", 4'b1000, 16'hF000, 5);

    // Wrap-around skipping idle channels
    do_txn("set_lg1", 4'b0010, 16'h0050, 0);
    do_txn("wrap", 4'b0001, 16'h0007, 0);
    do_txn("skip", 4'b1001, 16'h9006, 1);

    // Reset while holding a word
    req = 4'b0010; input1 = 4'hC; out_ready = 1'b0;
    cycle(); cycle();
    chk("prerst_valid", out_valid, 1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    req = 4'b0000;
    chk_reset_outputs("rst_hold");
    model_lg = 3;
    do_txn("after_rst", 4'b1111, 16'h8765, 0);

    // Randomized traffic
    for (int i = 0; i < 24; i++)
      do_txn("rand", 4'($urandom_range(1, 15)), 16'($urandom), $urandom_range(0, 3));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
